pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbitrates the instruction cache and data cache line-miss traffic onto the single burst physical-memory port of `mp4`. It sits directly downstream of both caches and drives the top-level `pmem_*` pins. It serialises 256-bit cache-line transfers into four 64-bit bursts and reassembles read bursts into lines. Only one transaction is in flight at a time.

## Interface
- `LINE_W`, 256, cache line width in bits
- `BEAT_W`, 64, burst beat width in bits
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `i_read`  in  1  icache line read request; held until `i_resp`
- `i_address`  in  32  icache line address
- `i_rdata`  out  256  icache line data; valid when `i_resp`=1
- `i_resp`  out  1  one-cycle completion pulse to icache
- `d_read`  in  1  dcache line read request
- `d_write`  in  1  dcache line writeback request; never asserted together with `d_read`
- `d_address`  in  32  dcache line address
- `d_wdata`  in  256  dcache writeback line
- `d_rdata`  out  256  dcache line data; valid when `d_resp`=1
- `d_resp`  out  1  one-cycle completion pulse to dcache
- `pmem_read` / `pmem_write`  out  1  burst read / write command
- `pmem_address`  out  32  line-aligned burst address (bits [4:0]=0)
- `pmem_wdata`  out  64  current write beat
- `pmem_rdata`  in  64  current read beat
- `pmem_resp`  in  1  high for exactly 4 consecutive cycles per burst, one per beat

## Operation
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE: sample requests.
  - `d_write` → D_WR.
  - `d_read` → D_RD.
  - `i_read` → I_RD.
  - Simultaneous icache and dcache requests follow the priority rule in Configuration.
  - On grant, latch the address with bits [4:0] cleared, the owner, and, for D_WR, `d_wdata`. Clear the beat counter (2 bits).
- I_RD / D_RD:
  - `pmem_read`=1.
  - Each cycle with `pmem_resp`=1 writes `pmem_rdata` into line slice [64k+63:64k], k = beat counter, then increments k.
  - The beat with k=3 → DONE.
- D_WR:
  - `pmem_write`=1 and `pmem_wdata` = latched line slice k.
  - k increments on each `pmem_resp`; the beat with k=3 → DONE.
- DONE:
  - Pulse the owner's `*_resp` for one cycle; `*_rdata` shows the assembled line for a read. `d_resp` is also pulsed for a writeback.
  - Next state IDLE.
- `i_rdata`/`d_rdata` hold the last assembled line until the next read burst overwrites the buffer.
- Request deasserted mid-burst: the burst completes and `resp` still pulses.
- `pmem_resp` outside I_RD/D_RD/D_WR is ignored.
- `pmem_read` and `pmem_write` are never both 1.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from any request input to `pmem_*`.
- Reset values: state IDLE, all `*_resp`/`pmem_read`/`pmem_write` = 0, `pmem_address` = 0, `pmem_wdata` = 0, `*_rdata` = 0, beat counter = 0, round-robin pointer = icache.
- Request seen at edge N → `pmem_*` command high from cycle N+1.
- Last `pmem_resp` at edge M → `*_resp` high in cycle M+1 → IDLE at M+2.
  - A pending request is granted at edge M+2; its command is high from M+3.
- Minimum turnaround between bursts: 2 idle command cycles.
- Asynchronous `rst` mid-burst: immediate return to IDLE with reset values; the partial line is discarded and no `resp` is issued.

## Configuration
- `PMEM_ARB_ROUND_ROBIN_EN` defined:
  - When icache and dcache request in the same IDLE cycle, the grant alternates.
  - A 1-bit pointer names the next preferred client and flips to the other client after each grant.
- Undefined: fixed priority, dcache (write before read) always over icache.
- Single-requester behaviour is identical in both builds.

## Structure
- Shared package `rv32i_types` gains:
  - `LINE_W`, `BEAT_W`, `BEATS`=4
  - enum `pmem_arb_state_t`
  - enum `pmem_owner_t` {ICACHE, DCACHE}
- Sub-module `cacheline_adapter` contains the 256-bit buffer, beat counter, slice write/select, and last-beat flag.
- `pmem_arbiter` contains the FSM, arbitration, and address/owner latches.

## Test plan
- icache read 0x0000_0064 alone, memory beats 0x1111…, 0x2222…, 0x3333…, 0x4444…
  - → `pmem_address`=0x0000_0060.
  - → `i_rdata`={0x4444…,0x3333…,0x2222…,0x1111…}.
  - → `i_resp` one cycle; `d_resp` stays 0.
- dcache writeback 0x8000_0020 with line words 0..7 = 0..7
  - → beats `pmem_wdata`=0x0000_0001_0000_0000, 0x…0003_…0002, 0x…0005_…0004, 0x…0007_…0006 in order.
  - → `d_resp` once.
- icache and dcache read asserted in the same cycle, twice back-to-back:
  - Fixed build: dcache, dcache.
  - Round-robin build: icache first, then dcache.
- icache drops `i_read` after beat 1 → burst finishes, `i_resp` still pulses, then IDLE.
- `rst` asserted after beat 2 of a dcache read → next cycle `pmem_read`=0, no `d_resp`; a following icache read completes normally.
- `pmem_resp` pulsed while IDLE → no state change, no outputs.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: line/beat geometry plus the
// arbiter state and owner encodings.
package rv32i_types;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } pmem_arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } pmem_owner_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts between 256-bit cache lines and four 64-bit memory beats.
// Holds the read reassembly buffer, the latched writeback line and the beat counter.
module cacheline_adapter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              load_w_i,
  input  logic [LINE_W-1:0] wline_i,
  input  logic              beat_en_i,
  input  logic              rd_en_i,
  input  logic [BEAT_W-1:0] rdata_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] wdata_o,
  output logic              last_o
);

  logic [1:0]        beat_q;
  logic [LINE_W-1:0] rline_q;
  logic [LINE_W-1:0] wline_q;
  logic [7:0]        base;

  assign base = {beat_q, 6'b0};

  // The read buffer is only touched by read bursts, so the last line survives writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= 2'd0;
      rline_q <= '0;
      wline_q <= '0;
    end else if (start_i) begin
      beat_q <= 2'd0;
      if (load_w_i) wline_q <= wline_i;
    end else if (beat_en_i) begin
      beat_q <= beat_q + 2'd1;
      if (rd_en_i) rline_q[base +: BEAT_W] <= rdata_i;
    end
  end

  assign line_o  = rline_q;
  assign wdata_o = wline_q[base +: BEAT_W];
  assign last_o  = (beat_q == 2'(BEATS - 1));

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates icache/dcache line misses onto the single burst memory port.
// Define PMEM_ARB_ROUND_ROBIN_EN for alternating grants on contention; otherwise dcache always wins.
module pmem_arbiter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t state_q;
  pmem_owner_t     owner_q;
  logic [31:0]     addr_q;
  logic [31:0]     addr_d;
  logic            read_q, write_q, iresp_q, dresp_q;
  logic            d_req, grant, grant_d, start, active, rd_active, beat_en, last_beat;
  logic [LINE_W-1:0] line;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  pmem_owner_t rr_q;
`endif

  always_comb begin
    d_req   = d_read | d_write;
    grant   = d_req | i_read;
    grant_d = d_req;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    if (d_req && i_read) grant_d = (rr_q == DCACHE);
`endif
    addr_d  = (grant_d ? d_address : i_address) & ~32'h1F;
  end

  assign start     = (state_q == IDLE) && grant;
  assign rd_active = (state_q == I_RD) || (state_q == D_RD);
  assign active    = rd_active || (state_q == D_WR);
  assign beat_en   = active && pmem_resp;

  // Command and response strobes are registered so no request input reaches the pins combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= ICACHE;
      addr_q  <= 32'h0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      iresp_q <= 1'b0;
      dresp_q <= 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      rr_q    <= ICACHE;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            addr_q  <= addr_d;
            owner_q <= grant_d ? DCACHE : ICACHE;
            read_q  <= !(grant_d && d_write);
            write_q <= grant_d && d_write;
            state_q <= !grant_d ? I_RD : (d_write ? D_WR : D_RD);
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            rr_q    <= grant_d ? ICACHE : DCACHE;
`endif
          end
        end
        I_RD, D_RD, D_WR: begin
          if (beat_en && last_beat) begin
            state_q <= DONE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            iresp_q <= (owner_q == ICACHE);
            dresp_q <= (owner_q == DCACHE);
          end
        end
        DONE: begin
          state_q <= IDLE;
          iresp_q <= 1'b0;
          dresp_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cacheline_adapter u_adapter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .load_w_i  (grant_d && d_write),
    .wline_i   (d_wdata),
    .beat_en_i (beat_en),
    .rd_en_i   (rd_active),
    .rdata_i   (pmem_rdata),
    .line_o    (line),
    .wdata_o   (pmem_wdata),
    .last_o    (last_beat)
  );

  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign i_resp       = iresp_q;
  assign d_resp       = dresp_q;
  assign i_rdata      = line;
  assign d_rdata      = line;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: a burst-memory model, a response monitor
// and directed stimulus; define PMEM_ARB_ROUND_ROBIN_EN to match that build.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0;
  logic [31:0]  i_address = 32'h0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_address = 32'h0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmemRdata = 64'h0;
  logic         modelResp = 1'b0;
  logic         strayResp = 1'b0;

  typedef struct {
    logic         isD;
    logic         chk;
    logic [255:0] line;
  } respExp_t;

  respExp_t    respQ[$];
  logic [31:0] addrQ[$];
  logic [63:0] wbeatQ[$];
  logic [63:0] beatTab[4];
  int          totalChecks = 0;
  int          passChecks = 0;
  int          beatCount = 0;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmemRdata),
    .pmem_resp    (modelResp | strayResp)
  );

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic pushResp(input logic isD, input logic chk, input logic [255:0] line);
    respExp_t e;
    e.isD  = isD;
    e.chk  = chk;
    e.line = line;
    respQ.push_back(e);
  endtask

  // Memory returns beatTab[b] plus address bits [15:8], so each line address gets distinct data.
  function automatic logic [255:0] expLine(input logic [7:0] off);
    return {beatTab[3] + {56'h0, off}, beatTab[2] + {56'h0, off},
            beatTab[1] + {56'h0, off}, beatTab[0] + {56'h0, off}};
  endfunction

  // Burst memory: four consecutive resp beats per command, abandoned if the command drops.
  initial begin
    forever begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !rst) begin
        if (addrQ.size() == 0) checkOutput("unexpectedBurst", 256'(pmem_address), 256'hX);
        else checkOutput("pmemAddr", 256'(pmem_address), 256'(addrQ.pop_front()));
        for (int b = 0; b < 4; b++) begin
          if (!(pmem_read || pmem_write)) break;
          pmemRdata = beatTab[b] + {56'h0, pmem_address[15:8]};
          if (pmem_write) begin
            if (wbeatQ.size() == 0) checkOutput("unexpectedWrBeat", 256'(pmem_wdata), 256'hX);
            else checkOutput("wrBeat", 256'(pmem_wdata), 256'(wbeatQ.pop_front()));
          end
          modelResp = 1'b1;
          beatCount++;
          @(negedge clk);
        end
        modelResp = 1'b0;
      end
    end
  end

  // Response monitor: every resp pulse must match the next expected completion.
  always @(negedge clk) begin
    if (i_resp || d_resp) begin
      if (i_resp && d_resp) checkOutput("dualResp", 256'({i_resp, d_resp}), 256'(2'b00));
      if (respQ.size() == 0) begin
        checkOutput("unexpectedResp", 256'({i_resp, d_resp}), 256'(2'b00));
      end else begin
        respExp_t e;
        e = respQ.pop_front();
        checkOutput("respOwner", 256'({i_resp, d_resp}), 256'({!e.isD, e.isD}));
        if (e.chk) checkOutput("rdata", d_resp ? d_rdata : i_rdata, e.line);
      end
    end
  end

  task automatic applyStimulus(input logic isD, input logic isWr, input logic [31:0] addr,
                               input logic [255:0] wline);
    logic seen;
    @(negedge clk);
    beatCount = 0;
    if (isD) begin
      d_address = addr;
      d_read    = !isWr;
      d_write   = isWr;
      d_wdata   = wline;
    end else begin
      i_address = addr;
      i_read    = 1'b1;
    end
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = isD ? d_resp : i_resp;
    end
    checkOutput("respTimeout", 256'(seen), 256'(1'b1));
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic waitBeats(input int n);
    int c;
    c = 0;
    while (beatCount < n && c < 100) begin
      @(posedge clk);
      c++;
    end
    checkOutput("beatWait", 256'(beatCount), 256'(n));
  endtask

  initial begin
    logic [255:0] wline;
    logic seen;
    int c;

    beatTab[0] = 64'h1111_1111_1111_1111;
    beatTab[1] = 64'h2222_2222_2222_2222;
    beatTab[2] = 64'h3333_3333_3333_3333;
    beatTab[3] = 64'h4444_4444_4444_4444;

    repeat (2) @(negedge clk);
    checkOutput("rstPmemRead", 256'(pmem_read), 256'(1'b0));
    checkOutput("rstPmemWrite", 256'(pmem_write), 256'(1'b0));
    checkOutput("rstResp", 256'({i_resp, d_resp}), 256'(2'b00));
    checkOutput("rstAddr", 256'(pmem_address), 256'(32'h0));
    checkOutput("rstWdata", 256'(pmem_wdata), 256'(64'h0));
    checkOutput("rstIRdata", i_rdata, 256'h0);
    checkOutput("rstDRdata", d_rdata, 256'h0);
    rst = 1'b0;

    $display("[TB] icache read 0x64");
    pushResp(1'b0, 1'b1, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    addrQ.push_back(32'h0000_0060);
    applyStimulus(1'b0, 1'b0, 32'h0000_0064, '0);

    $display("[TB] dcache writeback 0x80000020");
    wline = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    pushResp(1'b1, 1'b0, '0);
    addrQ.push_back(32'h8000_0020);
    wbeatQ.push_back(64'h0000_0001_0000_0000);
    wbeatQ.push_back(64'h0000_0003_0000_0002);
    wbeatQ.push_back(64'h0000_0005_0000_0004);
    wbeatQ.push_back(64'h0000_0007_0000_0006);
    applyStimulus(1'b1, 1'b1, 32'h8000_0020, wline);
    checkOutput("rdataHeldOverWb", i_rdata,
                256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    $display("[TB] icache drops request mid-burst");
    pushResp(1'b0, 1'b1, expLine(8'h01));
    addrQ.push_back(32'h0000_0140);
    @(negedge clk);
    beatCount = 0;
    i_address = 32'h0000_0140;
    i_read    = 1'b1;
    waitBeats(2);
    #1 i_read = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = i_resp;
    end
    checkOutput("dropResp", 256'(seen), 256'(1'b1));
    @(negedge clk);
    checkOutput("dropIdleCmd0", 256'(pmem_read), 256'(1'b0));
    @(negedge clk);
    checkOutput("dropIdleCmd1", 256'(pmem_read), 256'(1'b0));

    $display("[TB] stray pmem_resp in IDLE");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      strayResp = 1'b1;
      checkOutput("strayCmd", 256'({pmem_read, pmem_write}), 256'(2'b00));
    end
    @(negedge clk);
    strayResp = 1'b0;
    checkOutput("strayCmdAfter", 256'({pmem_read, pmem_write}), 256'(2'b00));

    $display("[TB] reset during dcache read");
    addrQ.push_back(32'h0000_0300);
    @(negedge clk);
    beatCount = 0;
    d_address = 32'h0000_0300;
    d_read    = 1'b1;
    waitBeats(3);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstMidPmemRead", 256'(pmem_read), 256'(1'b0));
    checkOutput("rstMidDResp", 256'(d_resp), 256'(1'b0));
    checkOutput("rstMidDRdata", d_rdata, 256'h0);
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    pushResp(1'b0, 1'b1, expLine(8'h04));
    addrQ.push_back(32'h0000_0400);
    applyStimulus(1'b0, 1'b0, 32'h0000_0408, '0);

    $display("[TB] simultaneous icache/dcache reads");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      pushResp(1'b0, 1'b1, expLine(8'h01));
      addrQ.push_back(32'h0000_0100);
      pushResp(1'b1, 1'b1, expLine(8'h02));
      addrQ.push_back(32'h0000_0200);
`else
      pushResp(1'b1, 1'b1, expLine(8'h02));
      addrQ.push_back(32'h0000_0200);
      pushResp(1'b0, 1'b1, expLine(8'h01));
      addrQ.push_back(32'h0000_0100);
`endif
      @(negedge clk);
      i_address = 32'h0000_0100;
      d_address = 32'h0000_0200;
      i_read    = 1'b1;
      d_read    = 1'b1;
      c = 0;
      while ((i_read || d_read) && c < 150) begin
        @(negedge clk);
        if (i_resp) i_read = 1'b0;
        if (d_resp) d_read = 1'b0;
        c++;
      end
      checkOutput("collideDone", 256'({i_read, d_read}), 256'(2'b00));
      i_read = 1'b0;
      d_read = 1'b0;
    end

    repeat (4) @(negedge clk);
    checkOutput("respQDrained", 256'(respQ.size()), 256'(0));
    checkOutput("addrQDrained", 256'(addrQ.size()), 256'(0));
    checkOutput("wbeatQDrained", 256'(wbeatQ.size()), 256'(0));

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", passChecks, totalChecks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
